ex_mem_stage: RTL and testbench

//  EX->MEM pipeline stage of the 5-stage ARM CPU. Registers the ALU result (incl. the 64-bit XOR path), store

---
 rtl/ex_mem_stage.sv | 108 ++++++++++
 tb/tb_ex_mem_stage.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX->MEM pipeline register with architectural NZCV flags
//
// Purpose: registers one instruction per cycle from EX into MEM (ALU result,
// store data, destination, MEM/WB controls, zero detect) and owns the NZCV
// flag register, which only flag-setting ops (ADDS/SUBS/ANDS) update.
// Priority per edge: flush (bubble) > stall (hold) > load.
//
// Optional feature macro: FLAG_BYPASS_EN
//   defined   : flags_cond forwards ex_flags combinationally for a valid,
//               loading flag-setter so B.cond right behind it needs no stall.
//   undefined : flags_cond = flags_q.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   ex_valid                  EX holds a real instruction
//   ex_alu_result [DATA_W]    ALU output
//   ex_store_data [DATA_W]    forwarded Rt for STUR
//   ex_rd [REG_AW]            destination register
//   ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg   controls
//   ex_set_flags, ex_flags[4] flag update enable and {N,Z,C,V}
//   stall, flush              hold / bubble
//   mem_valid, mem_alu_result, mem_store_data, mem_rd        registered stage
//   mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg  gated controls
//   mem_zero                  registered (ex_alu_result == 0)
//   flags_q[4]                architectural NZCV
//   flags_cond[4]             NZCV seen by B.cond

module ex_mem_stage #(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_mem_to_reg,
  input  logic              ex_set_flags,
  input  logic [3:0]        ex_flags,
  input  logic              stall,
  input  logic              flush,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_AW-1:0] mem_rd,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              mem_mem_to_reg,
  output logic              mem_zero,
  output logic [3:0]        flags_q,
  output logic [3:0]        flags_cond
);

  // A flush only has to kill the controls; data registers keep their old
  // contents since nothing downstream consumes them while mem_valid is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_valid      <= 1'b0;
      mem_alu_result <= '0;
      mem_store_data <= '0;
      mem_rd         <= '0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_mem_to_reg <= 1'b0;
      mem_zero       <= 1'b0;
      flags_q        <= 4'b0000;
    end else if (flush) begin
      mem_valid      <= 1'b0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_mem_to_reg <= 1'b0;
    end else if (!stall) begin
      mem_valid      <= ex_valid;
      mem_alu_result <= ex_alu_result;
      mem_store_data <= ex_store_data;
      mem_rd         <= ex_rd;
      // Controls are gated so a bubble can never write the RF or memory.
      mem_reg_write  <= ex_reg_write  & ex_valid;
      mem_mem_read   <= ex_mem_read   & ex_valid;
      mem_mem_write  <= ex_mem_write  & ex_valid;
      mem_mem_to_reg <= ex_mem_to_reg & ex_valid;
      mem_zero       <= (ex_alu_result == '0);
      if (ex_valid && ex_set_flags) begin
        flags_q <= ex_flags;
      end
    end
  end

`ifdef FLAG_BYPASS_EN
  assign flags_cond = (ex_valid & ex_set_flags & ~stall & ~flush) ? ex_flags : flags_q;
`else
  assign flags_cond = flags_q;
`endif

  // A load and a store in one instruction is an illegal decode.
  a_no_read_and_write: assert property (
    @(posedge clk) disable iff (!reset_n)
    (ex_valid && !stall && !flush) |-> !(ex_mem_read && ex_mem_write)
  );

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - scoreboard bench for ex_mem_stage
module tb_ex_mem_stage;

  logic        clk;
  logic        reset_n;
  logic        ex_valid;
  logic [63:0] ex_alu_result;
  logic [63:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic        ex_set_flags;
  logic [3:0]  ex_flags;
  logic        stall, flush;
  logic        mem_valid;
  logic [63:0] mem_alu_result, mem_store_data;
  logic [4:0]  mem_rd;
  logic        mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
  logic        mem_zero;
  logic [3:0]  flags_q, flags_cond;

  ex_mem_stage #(.DATA_W(64), .REG_AW(5)) dut (
    .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_set_flags(ex_set_flags), .ex_flags(ex_flags),
    .stall(stall), .flush(flush), .mem_valid(mem_valid),
    .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_zero(mem_zero), .flags_q(flags_q),
    .flags_cond(flags_cond)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [63:0] alu;
    logic [63:0] sd;
    logic [4:0]  rd;
    logic        rw, mr, mw, m2r, zero;
    logic [3:0]  flags;
    logic        known;   // data fields defined (not left over from a flush)
  } exp_t;

  exp_t m;
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t zero_state();
    exp_t z;
    z.valid = 0; z.alu = '0; z.sd = '0; z.rd = '0;
    z.rw = 0; z.mr = 0; z.mw = 0; z.m2r = 0; z.zero = 0;
    z.flags = 4'b0000; z.known = 1;
    return z;
  endfunction

  task automatic compare_outputs(input exp_t e);
    check("mem_valid", {63'd0, mem_valid}, {63'd0, e.valid});
    check("mem_reg_write", {63'd0, mem_reg_write}, {63'd0, e.rw});
    check("mem_mem_read", {63'd0, mem_mem_read}, {63'd0, e.mr});
    check("mem_mem_write", {63'd0, mem_mem_write}, {63'd0, e.mw});
    check("mem_mem_to_reg", {63'd0, mem_mem_to_reg}, {63'd0, e.m2r});
    check("flags_q", {60'd0, flags_q}, {60'd0, e.flags});
    if (e.known) begin
      check("mem_alu_result", mem_alu_result, e.alu);
      check("mem_store_data", mem_store_data, e.sd);
      check("mem_rd", {59'd0, mem_rd}, {59'd0, e.rd});
      check("mem_zero", {63'd0, mem_zero}, {63'd0, e.zero});
    end
  endtask

  // Entered and left at posedge+1. Drives one cycle, checks flags_cond before
  // the edge, pushes the predicted stage state and pops/compares after it.
  task automatic cycle(input logic v, input logic [63:0] alu, input logic [63:0] sd,
                       input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                       input logic m2r, input logic sf, input logic [3:0] fl,
                       input logic st, input logic fs);
    exp_t n;
    exp_t got;
    logic [3:0] fc;
    ex_valid = v; ex_alu_result = alu; ex_store_data = sd; ex_rd = rd;
    ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw; ex_mem_to_reg = m2r;
    ex_set_flags = sf; ex_flags = fl; stall = st; flush = fs;
    #1;
`ifdef FLAG_BYPASS_EN
    fc = (v && sf && !st && !fs) ? fl : m.flags;
`else
    fc = m.flags;
`endif
    check("flags_cond", {60'd0, flags_cond}, {60'd0, fc});
    n = m;
    if (fs) begin
      n.valid = 0; n.rw = 0; n.mr = 0; n.mw = 0; n.m2r = 0; n.known = 0;
    end else if (!st) begin
      n.valid = v; n.alu = alu; n.sd = sd; n.rd = rd;
      n.rw = rw & v; n.mr = mr & v; n.mw = mw & v; n.m2r = m2r & v;
      n.zero = (alu == 64'd0); n.known = 1;
      if (v && sf) n.flags = fl;
    end
    sb.push_back(n);
    m = n;
    @(posedge clk);
    #1;
    got = sb.pop_front();
    compare_outputs(got);
  endtask

  // Asynchronous reset between edges; outputs must clear with no clock edge.
  task automatic async_reset();
    ex_valid = 0; ex_set_flags = 0; stall = 0; flush = 0;
    #2;
    reset_n = 0;
    #2;
    m = zero_state();
    compare_outputs(m);
    check("flags_cond_rst", {60'd0, flags_cond}, 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1;
  endtask

  initial begin
    reset_n = 0;
    ex_valid = 0; ex_alu_result = '0; ex_store_data = '0; ex_rd = '0;
    ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0; ex_mem_to_reg = 0;
    ex_set_flags = 0; ex_flags = '0; stall = 0; flush = 0;
    m = zero_state();
    @(posedge clk);
    #1;
    compare_outputs(m);
    reset_n = 1;

    // basic load, zero detect on full width, XZR pass-through
    cycle(1, 64'hFFFF_0000_FFFF_0000, 64'h1234, 5'd3, 1, 0, 0, 0, 0, 4'h0, 0, 0);
    cycle(1, 64'h0, 64'h5678, 5'd4, 1, 1, 0, 1, 0, 4'h0, 0, 0);
    cycle(1, 64'h8000_0000_0000_0000, 64'h0, 5'd31, 1, 0, 0, 0, 0, 4'h0, 0, 0);
    // bubble: controls gated off even though they are asserted
    cycle(0, 64'hDEAD, 64'hBEEF, 5'd7, 1, 0, 1, 1, 1, 4'hF, 0, 0);

    // SUBS then ADD: only SUBS updates flags
    cycle(1, 64'd1, 64'd0, 5'd1, 1, 0, 0, 0, 1, 4'b0100, 0, 0);
    cycle(1, 64'd2, 64'd0, 5'd2, 1, 0, 0, 0, 0, 4'b1001, 0, 0);

    // stall for three cycles with fresh inputs (including flag setters), then release
    for (int i = 0; i < 3; i++)
      cycle(1, {$urandom, $urandom}, {$urandom, $urandom}, 5'(i + 10), 1, 0, 1, 0, 1, 4'(i + 1), 1, 0);
    cycle(1, 64'hCAFE_F00D, 64'h77, 5'd9, 1, 1, 0, 1, 1, 4'b0010, 0, 0);

    // flush and stall together on a valid flag-setting STUR
    cycle(1, 64'h100, 64'hAA, 5'd0, 0, 0, 1, 0, 1, 4'b1111, 1, 1);
    cycle(1, 64'h200, 64'hBB, 5'd5, 1, 0, 0, 0, 0, 4'b0000, 0, 0);

    // reset mid-stream with a valid instruction in MEM, then bypass check
    async_reset();
    cycle(1, 64'h5, 64'h0, 5'd6, 1, 0, 0, 0, 1, 4'b0110, 0, 0);

    // randomised traffic
    for (int i = 0; i < 60; i++) begin
      int op;
      op = int'($urandom_range(0, 2));
      cycle(1'($urandom), ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom},
            {$urandom, $urandom}, 5'($urandom), 1'($urandom), op == 1, op == 2,
            1'($urandom), 1'($urandom), 4'($urandom),
            $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
